// File: rtl/rnn_mm_master.sv
// rtl/rnn_mm_master.sv - Command-driven initiator for the RNN accelerator memory-mapped slave port
// Optional feature macro: POLL_TIMEOUT_EN (bounds the number of reads a POLL may issue)
module rnn_mm_master #(
    parameter int RD_LAT         = 1,
    parameter int POLL_GAP       = 4,
    parameter int POLL_MAX_READS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("RD_LAT must be in 1..15");
    end
    if (POLL_GAP < 0 || POLL_GAP > 255) begin : g_bad_poll_gap
        $error("POLL_GAP must be in 0..255");
    end
    if (POLL_MAX_READS < 1) begin : g_bad_poll_max
        $error("POLL_MAX_READS must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        GAP,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  lat_q, lat_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        hit;

`ifdef POLL_TIMEOUT_EN
    localparam int RC_W = $clog2(POLL_MAX_READS + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(POLL_MAX_READS);
    logic [RC_W-1:0] rd_cnt_q, rd_cnt_d;
`endif

    // data_q holds the POLL mask; an all-zero mask completes on the first read
    assign hit = (data_q == 32'h0) || ((m_rdata & data_q) != 32'h0);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        lat_d      = lat_q;
        gap_d      = gap_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef POLL_TIMEOUT_EN
        rd_cnt_d   = rd_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef POLL_TIMEOUT_EN
                rd_cnt_d = '0;
`endif
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_WRITE: state_d = WR;
                        OP_READ,
                        OP_POLL:  state_d = RD;
                        default: begin
                            state_d    = RESP;
                            rsp_data_d = 32'h0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                state_d    = RESP;
                rsp_data_d = 32'h0;
                rsp_err_d  = 1'b0;
            end
            RD: begin
                state_d = RD_WAIT;
                lat_d   = 4'h0;
`ifdef POLL_TIMEOUT_EN
                rd_cnt_d = rd_cnt_q + 1'b1;
`endif
            end
            RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    if (op_q == OP_READ || hit) begin
                        state_d    = RESP;
                        rsp_data_d = m_rdata;
                        rsp_err_d  = 1'b0;
                    end
`ifdef POLL_TIMEOUT_EN
                    else if (rd_cnt_q == RC_MAX) begin
                        state_d    = RESP;
                        rsp_data_d = m_rdata;
                        rsp_err_d  = 1'b1;
                    end
`endif
                    else if (POLL_GAP == 0) begin
                        state_d = RD;
                    end else begin
                        state_d = GAP;
                        gap_d   = 8'h0;
                    end
                end else begin
                    lat_d = lat_q + 4'h1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = RD;
                end else begin
                    gap_d = gap_q + 8'h1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            lat_q      <= 4'h0;
            gap_q      <= 8'h0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
`ifdef POLL_TIMEOUT_EN
            rd_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            lat_q      <= lat_d;
            gap_q      <= gap_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef POLL_TIMEOUT_EN
            rd_cnt_q   <= rd_cnt_d;
`endif
        end
    end

    // Strobes are decoded straight from state so each access is exactly one cycle wide
    assign cmd_ready = (state_q == IDLE);
    assign m_read    = (state_q == RD);
    assign m_write   = (state_q == WR);
    assign m_addr    = (state_q == RD || state_q == WR) ? addr_q : 32'h0;
    assign m_wdata   = (state_q == WR) ? data_q : 32'h0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rnn_mm_master.sv
// tb/tb_rnn_mm_master.sv - Self-checking bench for rnn_mm_master with a cycle-schedule model
`timescale 1ns/1ps
module tb_rnn_mm_master;

    localparam int RD_LAT         = 2;
    localparam int POLL_GAP       = 4;
    localparam int POLL_MAX_READS = 3;
    localparam int MAXC           = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    rnn_mm_master #(
        .RD_LAT(RD_LAT),
        .POLL_GAP(POLL_GAP),
        .POLL_MAX_READS(POLL_MAX_READS)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Slave: per-read scripted values, else a fixed address map; data appears RD_LAT cycles after m_read
    logic [31:0] script[$];
    logic [31:0] pipe_d [0:15];

    function automatic logic [31:0] slave_mem(input logic [31:0] a);
        case (a)
            32'd4:   return 32'hDEADBEEF;
            32'd8:   return 32'h0000_0002;
            default: return {a[15:0], 16'h5A5A};
        endcase
    endfunction

    assign m_rdata = pipe_d[RD_LAT-1];

    initial begin
        logic [31:0] v;
        forever begin
            @(posedge clk);
            v = 32'h0;
            if (m_read === 1'b1) begin
                if (script.size() > 0) v = script.pop_front();
                else v = slave_mem(m_addr);
            end
            pipe_d[0] <= v;
            for (int i = 1; i < 16; i++) pipe_d[i] <= pipe_d[i-1];
        end
    end

    // Model: on acceptance, lay out the whole bus/response schedule in absolute cycles
    bit          exp_rd    [0:MAXC-1];
    bit          exp_wr    [0:MAXC-1];
    logic [31:0] exp_addr  [0:MAXC-1];
    logic [31:0] exp_wdata [0:MAXC-1];
    bit          busy    = 1'b0;
    bit          started = 1'b0;
    int          rsp_at  = -1;
    logic [31:0] rsp_d   = 32'h0;
    logic        rsp_e   = 1'b0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;

    function automatic logic [31:0] read_val(input logic [31:0] a, input int k);
        if (k - 1 < script.size()) return script[k-1];
        return slave_mem(a);
    endfunction

    task automatic put(input int t, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (t >= 0 && t < MAXC) begin
            exp_rd[t]    = rd;
            exp_wr[t]    = wr;
            exp_addr[t]  = a;
            exp_wdata[t] = wd;
        end
    endtask

    task automatic schedule(input int n);
        int          t;
        logic [31:0] v;
        acc_cyc = n;
        acc_cnt++;
        busy  = 1'b1;
        rsp_d = 32'h0;
        rsp_e = 1'b0;
        case (cmd_op)
            2'b00: begin
                put(n + 1, 1'b0, 1'b1, cmd_addr, cmd_data);
                rsp_at = n + 2;
            end
            2'b01: begin
                put(n + 1, 1'b1, 1'b0, cmd_addr, 32'h0);
                rsp_at = n + 2 + RD_LAT;
                rsp_d  = read_val(cmd_addr, 1);
            end
            2'b10: begin
                rsp_at = -1;
                for (int k = 1; k <= 64 && rsp_at < 0; k++) begin
                    t = n + 1 + (k - 1) * (1 + RD_LAT + POLL_GAP);
                    put(t, 1'b1, 1'b0, cmd_addr, 32'h0);
                    v = read_val(cmd_addr, k);
                    if (cmd_data == 32'h0 || (v & cmd_data) != 32'h0) begin
                        rsp_at = t + RD_LAT + 1;
                        rsp_d  = v;
                    end
`ifdef POLL_TIMEOUT_EN
                    else if (k == POLL_MAX_READS) begin
                        rsp_at = t + RD_LAT + 1;
                        rsp_d  = v;
                        rsp_e  = 1'b1;
                    end
`endif
                end
            end
            default: begin
                rsp_at = n + 1;
                rsp_e  = 1'b1;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                busy    = 1'b0;
                rsp_at  = -1;
                started = 1'b1;
                for (int i = cyc + 1; i < MAXC; i++) begin
                    exp_rd[i] = 1'b0;
                    exp_wr[i] = 1'b0;
                end
            end else if (busy) begin
                if (rsp_at >= 0 && cyc >= rsp_at && rsp_ready) begin
                    busy   = 1'b0;
                    rsp_at = -1;
                end
            end else if (cmd_valid) begin
                schedule(cyc);
            end
            cyc++;
        end
    end

    // Per-cycle compare of every output against the model
    initial begin
        bit          er, ew, ev;
        logic [31:0] ea, ewd;
        forever begin
            @(negedge clk);
            if (started && cyc < MAXC) begin
                er  = exp_rd[cyc];
                ew  = exp_wr[cyc];
                ea  = (er || ew) ? exp_addr[cyc] : 32'h0;
                ewd = ew ? exp_wdata[cyc] : 32'h0;
                ev  = busy && rsp_at >= 0 && cyc >= rsp_at;
                chk("m_read", m_read, er);
                chk("m_write", m_write, ew);
                chk("m_addr", m_addr, ea);
                chk("m_wdata", m_wdata, ewd);
                chk("cmd_ready", cmd_ready, !busy);
                chk("rsp_valid", rsp_valid, ev);
                chk("rsp_data", rsp_data, ev ? rsp_d : 32'h0);
                chk("rsp_err", rsp_err, ev ? rsp_e : 1'b0);
            end
        end
    end

    int  rd_pulses = 0;
    int  wr_pulses = 0;
    int  rsp_rises = 0;
    bit  prev_v    = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_read === 1'b1)  rd_pulses++;
            if (m_write === 1'b1) wr_pulses++;
            if (rsp_valid === 1'b1 && !prev_v) rsp_rises++;
            prev_v = (rsp_valid === 1'b1);
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        int start;
        bit ok;
        start = acc_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) ok = 1'b1;
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h0;
        chk("cmd_accepted", ok, 1'b1);
    endtask

    task automatic recv(input int hold, output logic [31:0] d, output logic e, output int lat);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        chk("rsp_seen", got, 1'b1);
        lat = cyc - acc_cyc;
        repeat (hold) @(negedge clk);
        d = rsp_data;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          b_rd, b_wr, b_rsp;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_m_addr", m_addr, 32'h0);

        b_rd = rd_pulses; b_wr = wr_pulses;
        send(2'b00, 32'd1, 32'h0000FFFF);
        recv(0, d, e, lat);
        chk("wr_latency", lat, 2);
        chk("wr_rsp_data", d, 32'h0);
        chk("wr_rsp_err", e, 1'b0);
        chk("wr_pulses", wr_pulses - b_wr, 1);
        chk("wr_no_read", rd_pulses - b_rd, 0);

        b_rd = rd_pulses;
        send(2'b01, 32'd4, 32'h0);
        recv(0, d, e, lat);
        chk("rd_latency", lat, 4);
        chk("rd_rsp_data", d, 32'hDEADBEEF);
        chk("rd_pulses", rd_pulses - b_rd, 1);

        b_rd = rd_pulses;
        script = '{32'h0, 32'h0, 32'h1};
        send(2'b10, 32'd0, 32'h1);
        recv(0, d, e, lat);
        chk("poll_latency", lat, 18);
        chk("poll_rsp_data", d, 32'h1);
        chk("poll_rsp_err", e, 1'b0);
        chk("poll_pulses", rd_pulses - b_rd, 3);

        b_rd = rd_pulses; b_wr = wr_pulses;
        send(2'b01, 32'd4, 32'h0);
        recv(10, d, e, lat);
        chk("hold_rsp_data", d, 32'hDEADBEEF);
        chk("hold_pulses", (rd_pulses - b_rd) + (wr_pulses - b_wr), 1);

        b_rd = rd_pulses; b_wr = wr_pulses;
        send(2'b11, 32'h20, 32'h1234);
        recv(0, d, e, lat);
        chk("rsv_latency", lat, 1);
        chk("rsv_rsp_data", d, 32'h0);
        chk("rsv_rsp_err", e, 1'b1);
        chk("rsv_no_strobe", (rd_pulses - b_rd) + (wr_pulses - b_wr), 0);

        b_rd = rd_pulses;
        send(2'b10, 32'h10, 32'h0);
        recv(0, d, e, lat);
        chk("mask0_latency", lat, 4);
        chk("mask0_rsp_data", d, 32'h00105A5A);
        chk("mask0_pulses", rd_pulses - b_rd, 1);

        script = '{32'h0, 32'h0, 32'h0, 32'h0};
        send(2'b10, 32'd0, 32'h1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        script.delete();
        @(negedge clk);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mid_m_read", m_read, 1'b0);
        b_rd = rd_pulses; b_rsp = rsp_rises;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_reads", rd_pulses - b_rd, 0);
        chk("rst_mid_no_rsp", rsp_rises - b_rsp, 0);

`ifdef POLL_TIMEOUT_EN
        b_rd = rd_pulses;
        send(2'b10, 32'd8, 32'h1);
        recv(0, d, e, lat);
        chk("timeout_pulses", rd_pulses - b_rd, 3);
        chk("timeout_rsp_err", e, 1'b1);
        chk("timeout_rsp_data", d, 32'h2);
        chk("timeout_latency", lat, 18);
`endif

        b_wr = wr_pulses;
        send(2'b00, 32'h40, 32'hA5A5A5A5);
        recv(0, d, e, lat);
        chk("wr2_latency", lat, 2);
        chk("wr2_pulses", wr_pulses - b_wr, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
